release_arbiter: RTL and testbench



---
 rtl/release_arbiter_if.sv | 24 ++
 rtl/release_arbiter.sv | 100 ++++++++++
 tb/tb_release_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/release_arbiter_if.sv
// Release channel bundle: valid/ready handshake plus the release message fields.
// The arbiter uses master on its output side and slave on its inputs.
interface release_if #(
    parameter int DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [1:0]        addr_beat;
    logic [25:0]       addr_block;
    logic [1:0]        client_xact_id;
    logic              voluntary;
    logic [2:0]        r_type;
    logic [DATA_W-1:0] data;

    modport master (
        output valid, addr_beat, addr_block, client_xact_id, voluntary, r_type, data,
        input  ready
    );

    modport slave (
        input  valid, addr_beat, addr_block, client_xact_id, voluntary, r_type, data,
        output ready
    );
endinterface

// File: rtl/release_arbiter.sv
// Two-input locking release arbiter: writeback (input 0) beats probe replies (input 1),
// and a granted data-carrying release holds the channel until all its beats have gone.
module release_arbiter #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 128
) (
    input  logic     clk,
    input  logic     reset,
    release_if.slave  io_in_0,
    release_if.slave  io_in_1,
    release_if.master io_out,
    output logic     io_chosen,
    output logic     io_locked
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              lock_idx_reg, lock_idx_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic              lock_active;
    logic              chosen;
    logic              fire;
    logic [DATA_W-1:0] data_sel;

    // Reset gates the lock immediately so outputs follow plain priority while it is held.
    assign lock_active = (state_reg == LOCKED) && !reset;

    always_comb begin
        chosen = lock_active ? lock_idx_reg : !io_in_0.valid;

        if (lock_active) begin
            io_out.valid = lock_idx_reg ? io_in_1.valid : io_in_0.valid;
        end else begin
            io_out.valid = io_in_0.valid || io_in_1.valid;
        end

        io_in_0.ready = io_out.ready && !chosen;
        io_in_1.ready = io_out.ready && chosen;

        io_out.addr_beat      = chosen ? io_in_1.addr_beat      : io_in_0.addr_beat;
        io_out.addr_block     = chosen ? io_in_1.addr_block     : io_in_0.addr_block;
        io_out.client_xact_id = chosen ? io_in_1.client_xact_id : io_in_0.client_xact_id;
        io_out.voluntary      = chosen ? io_in_1.voluntary      : io_in_0.voluntary;
        io_out.r_type         = chosen ? io_in_1.r_type         : io_in_0.r_type;
        data_sel              = chosen ? io_in_1.data           : io_in_0.data;
        io_out.data           = data_sel;

        io_chosen = chosen;
        io_locked = lock_active;
    end

    assign fire = io_out.valid && io_out.ready;

    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        beat_cnt_next = beat_cnt_reg;

        if (fire) begin
            case (state_reg)
                UNLOCKED: begin
                    // Only data-carrying types span multiple beats; single-beat builds never lock.
                    if ((BEATS > 1) && (io_out.r_type < 3'd3)) begin
                        state_next    = LOCKED;
                        lock_idx_next = chosen;
                        beat_cnt_next = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        state_next    = UNLOCKED;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= UNLOCKED;
            lock_idx_reg <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end
endmodule

// File: tb/tb_release_arbiter.sv
// Randomized bench for release_arbiter: a 4-beat and a 1-beat build share stimulus and
// are both checked every cycle against a beats-remaining model of the locking rules.
module tb_release_arbiter;
    localparam int DATA_W = 128;

    typedef struct packed {
        logic [1:0]        beat;
        logic [25:0]       block;
        logic [1:0]        xid;
        logic              vol;
        logic [2:0]        rtype;
        logic [DATA_W-1:0] data;
    } bits_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  v0, v1, ordy;
    bits_t b0, b1;
    logic  checking = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    release_if #(.DATA_W(DATA_W)) a_in0 (), a_in1 (), a_out ();
    release_if #(.DATA_W(DATA_W)) s_in0 (), s_in1 (), s_out ();
    logic a_chosen, a_locked, s_chosen, s_locked;

    assign a_in0.valid = v0;
    assign a_in1.valid = v1;
    assign s_in0.valid = v0;
    assign s_in1.valid = v1;
    assign {a_in0.addr_beat, a_in0.addr_block, a_in0.client_xact_id, a_in0.voluntary, a_in0.r_type, a_in0.data} = b0;
    assign {a_in1.addr_beat, a_in1.addr_block, a_in1.client_xact_id, a_in1.voluntary, a_in1.r_type, a_in1.data} = b1;
    assign {s_in0.addr_beat, s_in0.addr_block, s_in0.client_xact_id, s_in0.voluntary, s_in0.r_type, s_in0.data} = b0;
    assign {s_in1.addr_beat, s_in1.addr_block, s_in1.client_xact_id, s_in1.voluntary, s_in1.r_type, s_in1.data} = b1;
    assign a_out.ready = ordy;
    assign s_out.ready = ordy;

    release_arbiter #(.BEATS(4), .DATA_W(DATA_W)) dut_a (
        .clk(clk), .reset(reset), .io_in_0(a_in0), .io_in_1(a_in1), .io_out(a_out),
        .io_chosen(a_chosen), .io_locked(a_locked)
    );

    release_arbiter #(.BEATS(1), .DATA_W(DATA_W)) dut_s (
        .clk(clk), .reset(reset), .io_in_0(s_in0), .io_in_1(s_in1), .io_out(s_out),
        .io_chosen(s_chosen), .io_locked(s_locked)
    );

    // Observed outputs per build: {out_valid, chosen, in0_ready, in1_ready, locked} and out bits.
    logic [4:0] act_ctl [2];
    bits_t      act_bits[2];
    assign act_ctl[0]  = {a_out.valid, a_chosen, a_in0.ready, a_in1.ready, a_locked};
    assign act_ctl[1]  = {s_out.valid, s_chosen, s_in0.ready, s_in1.ready, s_locked};
    assign act_bits[0] = {a_out.addr_beat, a_out.addr_block, a_out.client_xact_id, a_out.voluntary, a_out.r_type, a_out.data};
    assign act_bits[1] = {s_out.addr_beat, s_out.addr_block, s_out.client_xact_id, s_out.voluntary, s_out.r_type, s_out.data};

    // Model: a burst is just "owner" plus "beats still owed"; nothing else is remembered.
    int   remaining[2] = '{0, 0};
    logic owner[2]     = '{1'b0, 1'b0};
    int   beats_of[2]  = '{4, 1};
    logic       m_lk, m_ch, m_v;
    logic [4:0] m_ctl;
    bits_t      m_bits;

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                m_lk   = (remaining[k] > 0) && !reset;
                m_ch   = m_lk ? owner[k] : !v0;
                m_v    = m_lk ? (owner[k] ? v1 : v0) : (v0 || v1);
                m_ctl  = {m_v, m_ch, ordy && !m_ch, ordy && m_ch, m_lk};
                m_bits = m_ch ? b1 : b0;
                vectors++;
                if (act_ctl[k] !== m_ctl || act_bits[k] !== m_bits) begin
                    miscompares++;
                    $display("FAIL cycle_check build%0d t=%0t: ctl got %b expected %b, r_type got %0d expected %0d, beat got %0d expected %0d",
                             k, $time, act_ctl[k], m_ctl, act_bits[k].rtype, m_bits.rtype, act_bits[k].beat, m_bits.beat);
                end
                if (reset) begin
                    remaining[k] = 0;
                    owner[k]     = 1'b0;
                end else if (m_v && ordy) begin
                    if (k == 0)
                        $display("release fire in%0d beat %0d r_type %0d locked %0d", m_ch, m_bits.beat, m_bits.rtype, m_lk);
                    if (m_lk) begin
                        remaining[k] = remaining[k] - 1;
                    end else if (m_bits.rtype < 3'd3 && beats_of[k] > 1) begin
                        remaining[k] = beats_of[k] - 1;
                        owner[k]     = m_ch;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic a, input logic e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    function automatic bits_t rnd_bits();
        bits_t r;
        r.beat  = 2'($urandom_range(3));
        r.block = 26'($urandom);
        r.xid   = 2'($urandom_range(3));
        r.vol   = 1'($urandom_range(1));
        r.rtype = ($urandom_range(1) == 1) ? 3'($urandom_range(2)) : 3'($urandom_range(7, 3));
        r.data  = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    initial begin
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        b0 = '0; b1 = '0;
        step();
        checking = 1'b1;
        step();
        #2;
        chk("reset_locked", a_locked, 1'b0);
        chk("reset_out_valid", a_out.valid, 1'b0);

        // Burst lock: input 1 sends a 4-beat release, input 0 joins at beat 1.
        step();
        reset = 1'b0; v1 = 1'b1; b1.rtype = 3'd0; b1.beat = 2'd0;
        #2;
        chk("burst_first_chosen", a_chosen, 1'b1);
        chk("burst_first_locked", a_locked, 1'b0);
        chk("burst_first_ready1", a_in1.ready, 1'b1);
        for (int beat = 1; beat < 4; beat++) begin
            step();
            b1.beat = 2'(beat); v0 = 1'b1; b0.rtype = 3'd3;
            #2;
            chk("burst_locked", a_locked, 1'b1);
            chk("burst_chosen", a_chosen, 1'b1);
            chk("burst_ready0_blocked", a_in0.ready, 1'b0);
            chk("single_beat_never_locks", s_locked, 1'b0);
        end
        step();
        v1 = 1'b0;
        #2;
        chk("after_burst_unlocked", a_locked, 1'b0);
        chk("after_burst_chosen0", a_chosen, 1'b0);
        chk("after_burst_ready0", a_in0.ready, 1'b1);

        // Reset two beats into an input 1 burst, with input 0 waiting.
        step();
        v0 = 1'b0; v1 = 1'b1; b1.rtype = 3'd1; b1.beat = 2'd0;
        step();
        b1.beat = 2'd1;
        step();
        reset = 1'b1; v0 = 1'b1;
        #2;
        chk("in_reset_locked", a_locked, 1'b0);
        chk("in_reset_chosen", a_chosen, 1'b0);
        step();
        reset = 1'b0;
        #2;
        chk("post_reset_locked", a_locked, 1'b0);
        chk("post_reset_ready0", a_in0.ready, 1'b1);

        // Random traffic with backpressure and occasional reset.
        for (int n = 0; n < 4000; n++) begin
            step();
            reset = ($urandom_range(199) == 0);
            v0    = ($urandom_range(9) < 6);
            v1    = ($urandom_range(9) < 7);
            ordy  = ($urandom_range(3) != 0);
            b0    = rnd_bits();
            b1    = rnd_bits();
        end
        step();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
